// File: rtl/sram_port_ctrl.sv
// Request sequencer in front of a 1R1W byte-masked SRAM macro.
// After reset it clears every entry, then forwards ready/valid read and write
// requests to the macro's W0/R0 ports. Read data is captured one cycle after
// issue into a small response FIFO; a credit check on req_ready guarantees
// that FIFO never overflows.
module sram_port_ctrl #(
   parameter int DEPTH = 512,
   parameter int DATA_W = 64,
   parameter int RESP_DEPTH = 2,
   parameter logic [DATA_W-1:0] INIT_VALUE = '0,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int MASK_W = DATA_W / 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [MASK_W-1:0] req_mask,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              init_done,
   output logic              mem_W0_clk,
   output logic              mem_W0_en,
   output logic [ADDR_W-1:0] mem_W0_addr,
   output logic [DATA_W-1:0] mem_W0_data,
   output logic [MASK_W-1:0] mem_W0_mask,
   output logic              mem_R0_clk,
   output logic              mem_R0_en,
   output logic [ADDR_W-1:0] mem_R0_addr,
   input  logic [DATA_W-1:0] mem_R0_data
);

   localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int OCC_W = $clog2(RESP_DEPTH + 1);
   localparam int CNT_W = OCC_W + 1;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t             state_reg, state_next;
   logic [ADDR_W-1:0]  init_addr_reg, init_addr_next;
   logic [OCC_W-1:0]   occ_reg, occ_next;
   logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
   logic               inflight_reg, inflight_next;
   logic [DATA_W-1:0]  fifo_mem [RESP_DEPTH];

   logic               in_init;
   logic               in_run;
   logic               pop;
   logic               push;
   logic [CNT_W-1:0]   credit_used;
   logic               rd_allowed;
   logic               wr_allowed;
   logic               rd_fire;
   logic               wr_fire;

   assign mem_W0_clk = clock;
   assign mem_R0_clk = clock;

   assign in_init = (state_reg == ST_INIT);
   assign in_run  = (state_reg == ST_RUN);

   // Init sequencing: walk the address counter once over the array, then run.
   always_comb begin
      state_next     = state_reg;
      init_addr_next = init_addr_reg;
      if (in_init) begin
         if (init_addr_reg == ADDR_W'(DEPTH - 1)) begin
            state_next     = ST_RUN;
            init_addr_next = '0;
         end else begin
            init_addr_next = init_addr_reg + ADDR_W'(1);
         end
      end
   end

   // Request acceptance. Read and write permission are formed independently
   // so req_write only acts as a final select, never inside the credit logic.
   // resp_ready feeds req_ready combinationally so a slot freed this cycle
   // can be reused immediately, sustaining one read per cycle.
   always_comb begin
      pop         = resp_valid && resp_ready;
      credit_used = CNT_W'(occ_reg) + CNT_W'(inflight_reg) - CNT_W'(pop);
      rd_allowed  = in_run && (credit_used < CNT_W'(RESP_DEPTH));
      wr_allowed  = in_run;
      req_ready   = req_write ? wr_allowed : rd_allowed;
      wr_fire     = req_valid && req_write && wr_allowed;
      rd_fire     = req_valid && !req_write && rd_allowed;
   end

   // Macro port drive: init clear owns W0 while initialising; afterwards W0
   // and R0 follow accepted requests in the same cycle. The write strobe is
   // held off while reset is asserted so the macro sees no spurious writes.
   always_comb begin
      mem_W0_en   = 1'b0;
      mem_W0_addr = req_addr;
      mem_W0_data = req_wdata;
      mem_W0_mask = req_mask;
      if (in_init) begin
         mem_W0_en   = !reset;
         mem_W0_addr = init_addr_reg;
         mem_W0_data = INIT_VALUE;
         mem_W0_mask = '1;
      end else begin
         mem_W0_en = wr_fire;
      end
      mem_R0_en   = rd_fire;
      mem_R0_addr = req_addr;
      init_done   = in_run;
   end

   // Response FIFO bookkeeping. The macro output is pushed unconditionally
   // the cycle after a read issues, before any later write can change it.
   always_comb begin
      push          = inflight_reg;
      inflight_next = rd_fire;
      occ_next      = occ_reg + OCC_W'(push) - OCC_W'(pop);
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      if (push) begin
         wr_ptr_next = (wr_ptr_reg == PTR_W'(RESP_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_next = (rd_ptr_reg == PTR_W'(RESP_DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
      end
      resp_valid = (occ_reg != '0);
      resp_data  = fifo_mem[rd_ptr_reg];
   end

   // Control state register; reset discards queued responses and restarts init.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg     <= ST_INIT;
         init_addr_reg <= '0;
         occ_reg       <= '0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         inflight_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         init_addr_reg <= init_addr_next;
         occ_reg       <= occ_next;
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         inflight_reg  <= inflight_next;
      end
   end

   // Response storage; contents are only meaningful below occ, so no reset.
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= mem_R0_data;
      end
   end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: behavioural SRAM macro, a word-level reference
// model with an ordered expected-response queue, a directed vector table,
// hand-written multi-cycle sequences and randomized traffic.
module tb_sram_port_ctrl;

   localparam int DEPTH = 512;
   localparam int DATA_W = 64;
   localparam int RESP_DEPTH = 2;
   localparam int ADDR_W = 9;
   localparam int MASK_W = 8;
   localparam logic [DATA_W-1:0] INIT_VALUE = '0;
   localparam int NVEC = 23;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_write = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [DATA_W-1:0] req_wdata = '0;
   logic [MASK_W-1:0] req_mask = '0;
   logic              resp_valid;
   logic              resp_ready = 1'b0;
   logic [DATA_W-1:0] resp_data;
   logic              init_done;
   logic              mem_W0_clk, mem_R0_clk;
   logic              mem_W0_en;
   logic [ADDR_W-1:0] mem_W0_addr;
   logic [DATA_W-1:0] mem_W0_data;
   logic [MASK_W-1:0] mem_W0_mask;
   logic              mem_R0_en;
   logic [ADDR_W-1:0] mem_R0_addr;
   logic [DATA_W-1:0] mem_R0_data;

   int vec_cnt = 0;
   int miscmp = 0;

   sram_port_ctrl #(
      .DEPTH(DEPTH), .DATA_W(DATA_W), .RESP_DEPTH(RESP_DEPTH), .INIT_VALUE(INIT_VALUE)
   ) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .init_done(init_done),
      .mem_W0_clk(mem_W0_clk), .mem_W0_en(mem_W0_en), .mem_W0_addr(mem_W0_addr),
      .mem_W0_data(mem_W0_data), .mem_W0_mask(mem_W0_mask),
      .mem_R0_clk(mem_R0_clk), .mem_R0_en(mem_R0_en), .mem_R0_addr(mem_R0_addr),
      .mem_R0_data(mem_R0_data)
   );

   always #5 clock = ~clock;

   // Behavioural macro: byte-masked write, registered read address.
   logic [DATA_W-1:0] sram [DEPTH];
   logic [ADDR_W-1:0] sram_raddr;
   always @(posedge clock) begin
      if (mem_W0_en) begin
         for (int b = 0; b < MASK_W; b++) begin
            if (mem_W0_mask[b]) sram[mem_W0_addr][8*b +: 8] <= mem_W0_data[8*b +: 8];
         end
      end
      if (mem_R0_en) sram_raddr <= mem_R0_addr;
   end
   assign mem_R0_data = sram[sram_raddr];

   task automatic chk1(input string name, input logic act, input logic exp);
      vec_cnt++;
      if (act !== exp) begin
         miscmp++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkd(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miscmp++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      vec_cnt++;
      if (act != exp) begin
         miscmp++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: array contents as seen by requests, plus the data
   // each accepted read must return, in acceptance order. A read sees every
   // write accepted in an earlier cycle; its data becomes visible two cycles
   // after acceptance.
   logic [DATA_W-1:0] ref_mem [DEPTH];
   logic [DATA_W-1:0] exp_q [$];
   bit                inflight_m = 1'b0;
   bit                model_clean = 1'b0;

   always @(negedge clock) begin : monitor
      int          outstanding;
      bit          pop_now;
      bit          exp_rd_ok;
      bit          exp_wen;
      bit          exp_ren;
      logic [DATA_W-1:0] e;
      if (reset || !init_done) begin
         if (!model_clean) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT_VALUE;
            exp_q.delete();
            inflight_m = 1'b0;
            model_clean = 1'b1;
         end
      end else begin
         model_clean = 1'b0;
         outstanding = exp_q.size();
         pop_now = resp_valid && resp_ready;
         exp_rd_ok = (outstanding - int'(pop_now)) < RESP_DEPTH;
         chk1("mon_resp_valid", resp_valid, (outstanding - int'(inflight_m)) != 0);
         chk1("mon_req_ready", req_ready, req_write ? 1'b1 : exp_rd_ok);
         exp_wen = req_valid && req_write;
         exp_ren = req_valid && !req_write && exp_rd_ok;
         chk1("mon_w0_en", mem_W0_en, exp_wen);
         chk1("mon_r0_en", mem_R0_en, exp_ren);
         if (exp_wen) begin
            chkd("mon_w0_addr", 64'(mem_W0_addr), 64'(req_addr));
            chkd("mon_w0_data", mem_W0_data, req_wdata);
            chkd("mon_w0_mask", 64'(mem_W0_mask), 64'(req_mask));
         end
         if (exp_ren) chkd("mon_r0_addr", 64'(mem_R0_addr), 64'(req_addr));
         if (pop_now) begin
            if (exp_q.size() == 0) begin
               chkd("mon_resp_unexpected", resp_data, 64'hx);
            end else begin
               e = exp_q.pop_front();
               chkd("mon_resp_data", resp_data, e);
               $display("resp data=%h expected=%h", resp_data, e);
            end
         end
         inflight_m = 1'b0;
         if (req_valid && req_ready) begin
            if (req_write) begin
               for (int b = 0; b < MASK_W; b++) begin
                  if (req_mask[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
               end
            end else begin
               exp_q.push_back(ref_mem[req_addr]);
               inflight_m = 1'b1;
               chk1("mon_no_overflow", exp_q.size() <= RESP_DEPTH, 1'b1);
            end
         end
      end
   end

   typedef struct {
      logic              valid;
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [MASK_W-1:0] mask;
      logic              rr;
      logic              exp_ready;
      logic              exp_rv;
      logic [DATA_W-1:0] exp_rdata;
   } vec_t;

   vec_t tbl [NVEC];

   function automatic vec_t mk(input logic v, input logic w, input int a, input logic [DATA_W-1:0] d,
                               input logic [MASK_W-1:0] m, input logic rr, input logic er,
                               input logic ev, input logic [DATA_W-1:0] ed);
      vec_t t;
      t.valid = v; t.write = w; t.addr = ADDR_W'(a); t.wdata = d; t.mask = m; t.rr = rr;
      t.exp_ready = er; t.exp_rv = ev; t.exp_rdata = ed;
      return t;
   endfunction

   // Reset, check reset values, release and watch the clear sequence.
   // stop_at >= 0 returns as soon as the clear reaches that address.
   task automatic do_init(input int stop_at);
      int good;
      int noisy;
      req_valid = 1'b0; req_write = 1'b0; resp_ready = 1'b1;
      reset = 1'b1;
      #1;
      chk1("rst_req_ready", req_ready, 1'b0);
      chk1("rst_resp_valid", resp_valid, 1'b0);
      chk1("rst_init_done", init_done, 1'b0);
      chk1("rst_w0_en", mem_W0_en, 1'b0);
      chk1("rst_r0_en", mem_R0_en, 1'b0);
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b0;
      good = 0;
      noisy = 0;
      for (int c = 0; c < DEPTH; c++) begin
         @(negedge clock);
         if (c == stop_at) begin
            chkd("abort_addr", 64'(mem_W0_addr), 64'(stop_at));
            $display("init interrupted at address %0d", mem_W0_addr);
            return;
         end
         if (mem_W0_en === 1'b1 && mem_W0_addr === ADDR_W'(c) && mem_W0_data === INIT_VALUE &&
             mem_W0_mask === '1) good++;
         if (req_ready !== 1'b0 || init_done !== 1'b0 || mem_R0_en !== 1'b0) noisy++;
      end
      chki("init_writes", good, DEPTH);
      chki("init_quiet", noisy, 0);
      @(negedge clock);
      chk1("init_done_rise", init_done, 1'b1);
      chk1("init_w0_idle", mem_W0_en, 1'b0);
      $display("init complete: %0d clear writes observed", good);
   endtask

   task automatic idle_cycles(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clock);
         #1;
         req_valid = 1'b0;
         resp_ready = 1'b1;
      end
      @(negedge clock);
   endtask

   task automatic read_burst(input int first_addr, input int n);
      for (int c = 0; c < n + 2; c++) begin
         @(posedge clock);
         #1;
         req_valid = (c < n);
         req_write = 1'b0;
         req_addr = ADDR_W'(first_addr + c);
         resp_ready = 1'b1;
         @(negedge clock);
         if (c < n) chk1("burst_req_ready", req_ready, 1'b1);
         if (c >= 2) chk1("burst_resp_valid", resp_valid, 1'b1);
         $display("burst cycle %0d ready=%b resp_valid=%b data=%h", c, req_ready, resp_valid, resp_data);
      end
   endtask

   initial begin
      tbl[0]  = mk(1, 1, 1, 64'h1111111111111111, 8'hFF, 1, 1, 0, 64'h0);
      tbl[1]  = mk(1, 1, 2, 64'h2222222222222222, 8'hFF, 1, 1, 0, 64'h0);
      tbl[2]  = mk(1, 1, 3, 64'h3333333333333333, 8'hFF, 1, 1, 0, 64'h0);
      tbl[3]  = mk(1, 1, 5, 64'h1122334455667788, 8'h0F, 1, 1, 0, 64'h0);
      tbl[4]  = mk(1, 0, 5, 64'h0, 8'h00, 1, 1, 0, 64'h0);
      tbl[5]  = mk(0, 0, 0, 64'h0, 8'h00, 1, 1, 0, 64'h0);
      tbl[6]  = mk(0, 0, 0, 64'h0, 8'h00, 1, 1, 1, 64'h0000000055667788);
      tbl[7]  = mk(1, 0, 1, 64'h0, 8'h00, 0, 1, 0, 64'h0);
      tbl[8]  = mk(1, 0, 2, 64'h0, 8'h00, 0, 1, 0, 64'h0);
      tbl[9]  = mk(1, 0, 3, 64'h0, 8'h00, 0, 0, 1, 64'h1111111111111111);
      tbl[10] = mk(1, 0, 3, 64'h0, 8'h00, 0, 0, 1, 64'h1111111111111111);
      tbl[11] = mk(1, 0, 3, 64'h0, 8'h00, 1, 1, 1, 64'h1111111111111111);
      tbl[12] = mk(0, 0, 0, 64'h0, 8'h00, 1, 1, 1, 64'h2222222222222222);
      tbl[13] = mk(0, 0, 0, 64'h0, 8'h00, 1, 1, 1, 64'h3333333333333333);
      tbl[14] = mk(1, 0, 7, 64'h0, 8'h00, 1, 1, 0, 64'h0);
      tbl[15] = mk(1, 1, 7, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1, 1, 0, 64'h0);
      tbl[16] = mk(1, 0, 7, 64'h0, 8'h00, 1, 1, 1, 64'h0);
      tbl[17] = mk(0, 0, 0, 64'h0, 8'h00, 1, 1, 0, 64'h0);
      tbl[18] = mk(0, 0, 0, 64'h0, 8'h00, 1, 1, 1, 64'hFFFFFFFFFFFFFFFF);
      tbl[19] = mk(1, 1, 9, 64'hDEADBEEFCAFEF00D, 8'h00, 1, 1, 0, 64'h0);
      tbl[20] = mk(1, 0, 9, 64'h0, 8'h00, 1, 1, 0, 64'h0);
      tbl[21] = mk(0, 0, 0, 64'h0, 8'h00, 1, 1, 0, 64'h0);
      tbl[22] = mk(0, 0, 0, 64'h0, 8'h00, 1, 1, 1, 64'h0);

      do_init(-1);

      for (int i = 0; i < NVEC; i++) begin
         @(posedge clock);
         #1;
         req_valid = tbl[i].valid;
         req_write = tbl[i].write;
         req_addr = tbl[i].addr;
         req_wdata = tbl[i].wdata;
         req_mask = tbl[i].mask;
         resp_ready = tbl[i].rr;
         @(negedge clock);
         chk1("tbl_req_ready", req_ready, tbl[i].exp_ready);
         chk1("tbl_resp_valid", resp_valid, tbl[i].exp_rv);
         if (tbl[i].exp_rv) chkd("tbl_resp_data", resp_data, tbl[i].exp_rdata);
         $display("vec %0d v=%b w=%b a=%0d rr=%b -> ready=%b resp_valid=%b data=%h",
                  i, tbl[i].valid, tbl[i].write, tbl[i].addr, tbl[i].rr, req_ready, resp_valid, resp_data);
      end

      // Ten back-to-back reads with the consumer always ready.
      read_burst(1, 10);

      // Random traffic concentrated on a few addresses to hit hazards.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clock);
         #1;
         req_valid = ($urandom_range(0, 3) != 0);
         req_write = 1'($urandom_range(0, 1));
         req_addr = ADDR_W'($urandom_range(0, 15));
         req_wdata = {$urandom, $urandom};
         req_mask = 8'($urandom);
         resp_ready = ($urandom_range(0, 3) != 0);
      end
      idle_cycles(6);
      chki("random_drained", exp_q.size(), 0);

      // Reset in the middle of the clear, then a full clear and readback.
      do_init(100);
      do_init(-1);
      read_burst(0, 16);
      idle_cycles(4);
      chki("final_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
      $finish;
   end

endmodule

// File: doc/sram_port_ctrl.md
Name: sram_port_ctrl

Overview:
- Request sequencer directly upstream of a 1R1W byte-masked SRAM macro (512 x 64, W0/R0 port style, 1-cycle registered-address read).
- Clears the array after reset, then accepts ready/valid read/write requests and drives the macro's W0/R0 ports.
- Captures read data exactly one cycle after issue into a small response FIFO, with full backpressure to the requester.

Parameters:
- DEPTH, 512, SRAM entries; ADDR_W = clog2(DEPTH) = 9.
- DATA_W, 64, word width; must be a multiple of 8.
- MASK_W, DATA_W/8 = 8, byte-enable width.
- RESP_DEPTH, 2, response FIFO entries (>= 2).
- INIT_VALUE, 0, word written to every entry during init.

Ports:
- clock  in  1  sole clock; also drives mem_W0_clk and mem_R0_clk.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_mask  in  MASK_W  byte enables, bit i -> bits [8i+7:8i].
- resp_valid  out  1  read data available.
- resp_ready  in  1  consumer takes data.
- resp_data  out  DATA_W  read data, returned in request order.
- init_done  out  1  high once the array clear has completed.
- mem_W0_clk, mem_R0_clk  out  1  = clock.
- mem_W0_en  out  1  write strobe.
- mem_W0_addr  out  ADDR_W  write address.
- mem_W0_data  out  DATA_W  write data.
- mem_W0_mask  out  MASK_W  write byte mask.
- mem_R0_en  out  1  read strobe.
- mem_R0_addr  out  ADDR_W  read address.
- mem_R0_data  in  DATA_W  macro read data, valid the cycle after mem_R0_en.

Behaviour:
- Reset values: FSM = INIT, init address counter = 0, FIFO empty, inflight = 0. Outputs: req_ready = 0, resp_valid = 0, init_done = 0, mem_W0_en = 0, mem_R0_en = 0.
- INIT state:
  - Each cycle: mem_W0_en = 1, mem_W0_addr = counter, mem_W0_data = INIT_VALUE, mem_W0_mask = all ones; counter increments.
  - After the write to DEPTH-1, go to RUN. That is DEPTH cycles of writes; init_done rises the next cycle.
  - req_ready = 0 throughout INIT.
  - Reset asserted mid-init restarts from address 0.
- RUN state, writes:
  - Accepted write drives mem_W0_* combinationally in the same cycle, mask passed through unchanged.
  - No response is produced.
  - A write with mask 0 is accepted and leaves the array unchanged.
- RUN state, reads:
  - Accepted read drives mem_R0_en = 1 and mem_R0_addr = req_addr in the same cycle; inflight is set for one cycle.
  - The cycle after issue, mem_R0_data is unconditionally pushed into the FIFO. The macro output follows later writes to the same address, so capture must not be deferred.
- req_ready in RUN:
  - Writes: always 1.
  - Reads: only when occ + inflight - pop < RESP_DEPTH, where pop = resp_valid && resp_ready.
  - The combinational path resp_ready -> req_ready is intentional; it allows one read per cycle sustained when resp_ready is held high.
  - req_ready must not depend on req_write from the same cycle in a way that forms a loop. Compute read-permission and write-permission separately and select with req_write.
- Response FIFO:
  - resp_valid = (occ != 0); resp_data = head entry. No FIFO bypass, so read-to-response latency is 2 cycles minimum.
  - Simultaneous push and pop leaves occ unchanged.
  - Overflow is impossible by the credit rule; the bench asserts it.
  - Pointers wrap modulo RESP_DEPTH.
- Ordering and hazards:
  - Read and write accepted back-to-back to the same address: the read returns the newly written data.
  - Write accepted the cycle after a read to the same address: the read returns the old data, because capture happens before the macro output changes.
- Reset in RUN: FIFO and inflight are discarded, the FSM re-enters INIT, and the array is cleared again.

Test Plan:
- Release reset, hold req_valid = 0 -> exactly 512 mem_W0_en pulses on addresses 0..511 with mask 0xFF and data 0. init_done rises the cycle after address 511; req_ready = 0 until then.
- After init: write addr 5, data 0x1122334455667788, mask 0x0F; then read addr 5 -> resp_data = 0x0000000055667788, resp_valid 2 cycles after read acceptance.
- resp_ready = 0 and reads issued back-to-back to addrs 1, 2, 3 -> two accepted, third stalls with req_ready = 0. Raise resp_ready -> responses return in order 1, 2, 3 and no data is lost.
- resp_ready held 1, 10 consecutive reads -> req_ready stays 1, one response per cycle, in order.
- Read addr 7, then next cycle write addr 7 with 0xFFFF..., mask 0xFF -> response equals the pre-write value (0 after init).
- Assert reset at init address 100 -> outputs return to reset values; after release, init restarts at address 0 and runs the full 512 cycles.
